xex_out_buffer: RTL and testbench
=================================

// Module: xex_out_buffer
// PURPOSE
//  Downstream stage of the combined SCU + XEX-AES-256 block. Captures each 128-bit
//  ciphertext/plaintext block presented on that block's out_rdy/data_out and queues it in
//  a small FIFO. Serialises the queue MSB-first into 32-bit words on a valid/ready host port.
//  Frames output per 4096-byte sector and drives backpressure into the SCU n_busy input.
// PARAMETERS
//  DEPTH              4    FIFO entries (128-bit blocks); power of two, >=2
//  BLOCKS_PER_SECTOR  256  AES blocks per sector (4096 B / 16 B)
// PORTS
//  clk            in   1    single clock, rising edge
//  rst            in   1    asynchronous, active-high reset
//  out_rdy        in   1    one-cycle strobe: data_out holds a valid AES block
//  data_out       in   128  AES result block
//  sector_start   in   1    sync pulse: flush FIFO, clear counters/flags, begin new sector
//  m_valid        out  1    m_data holds a valid word
//  m_data         out  32   output word
//  m_ready        in   1    host accepts word when m_valid & m_ready
//  m_last         out  1    current word is the final word of the sector
//  sector_done    out  1    one-cycle pulse after the sector's final word transfers
//  n_busy         out  1    backpressure to SCU: high when count >= DEPTH-1
//  overflow       out  1    sticky: block arrived with FIFO full and no pop that cycle
//  level          out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async, immediate): FIFO empty, level=0, word_idx=0, blk_cnt=0, m_valid=0,
//   m_data=0, m_last=0, sector_done=0, n_busy=0, overflow=0. Applies mid-transfer.
//   Partial blocks are discarded.
//  Push: out_rdy at edge N writes data_out to the tail. Earliest m_valid is cycle N+1,
//   i.e. one cycle of latency.
//  Output: m_valid = (level!=0). m_data = head[127-32*word_idx -: 32]. Word 0 is bits
//   [127:96]. m_data is 0 when empty.
//  Handshake: word_idx advances only on m_valid&m_ready. m_data and m_valid stay stable
//   while m_valid&!m_ready. On transfer of word 3: pop head, word_idx->0, blk_cnt++.
//  Simultaneous push+pop: always legal, including when full. Level is unchanged.
//  Full (level==DEPTH), out_rdy, no pop: block dropped and overflow<=1. The FIFO, pointers
//   and level are unchanged. overflow clears only on rst or sector_start.
//  Empty: m_valid=0. A host m_ready is ignored.
//  Pointers: $clog2(DEPTH) bits, wrap naturally modulo DEPTH. level is a separate counter.
//  Sector: m_last = m_valid & word_idx==3 & blk_cnt==BLOCKS_PER_SECTOR-1.
//   A transfer with m_last set: blk_cnt wraps to 0 and sector_done pulses the next cycle.
//   Blocks beyond the sector continue to flow. Counting restarts; no stall.
//  sector_start: synchronous. Flushes the FIFO, word_idx=0, blk_cnt=0, overflow=0.
//   It takes priority over a same-cycle pop. A same-cycle out_rdy is written after the
//   flush, giving level=1 as the first block of the new sector.
//  n_busy: combinational from the level register (level >= DEPTH-1). One entry of slack
//   covers the SCU's single-cycle reaction delay.
//  State: only counters and FIFO; no explicit FSM beyond word_idx {W0,W1,W2,W3} cycling
//   W0->W1->W2->W3->W0 on each transfer.
// STRUCTURE
//  Package xex_buf_pkg holds:
//   AES_BLK_W=128, WORD_W=32, WORDS_PER_BLK=4, SECTOR_BYTES=4096
//   typedef logic [AES_BLK_W-1:0] aes_blk_t, typedef logic [WORD_W-1:0] word_t
//  Sub-module blk_fifo: parameterised sync FIFO of aes_blk_t, async active-high rst,
//   with push/pop/flush/full/empty/level ports.
//  Top level holds the word serialiser, sector counter and flags.
// TESTING
//  1. Push 0x00112233_44556677_8899AABB_CCDDEEFF, m_ready=1 -> words 0x00112233,
//     0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles starting 1 cycle later.
//  2. m_ready=0 with 4 pushes (DEPTH=4) -> level=4, n_busy high from level 3.
//     A 5th push gives overflow=1 with FIFO contents unchanged.
//     m_ready=1 then drains 16 words in order.
//  3. level=4, push and word-3 transfer in the same cycle -> level stays 4, overflow=0,
//     and the new block appears last.
//  4. Stream 256 blocks with random m_ready -> m_last only on word 1023,
//     sector_done pulses once the next cycle, and blk_cnt=0 afterwards.
//  5. rst asserted mid-block (word_idx=2, level=3) -> all outputs 0 immediately.
//     sector_start with same-cycle out_rdy -> level=1, overflow cleared.

Source files
------------

// File: rtl/xex_buf_pkg.sv
// Shared types for the XEX-AES output buffer.
// Block and word widths plus word-select helper.
package xex_buf_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int SECTOR_BYTES  = 4096;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;
  typedef logic [WORD_W-1:0]    word_t;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2,
    W3 = 2'd3
  } word_idx_e;

  // Word 0 is the most significant 32 bits of the block.
  function automatic word_t blk_word(
    input aes_blk_t  blk,
    input word_idx_e idx
  );
    word_t w;
    unique case (idx)
      W0: w = blk[127:96];
      W1: w = blk[95:64];
      W2: w = blk[63:32];
      W3: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/xex_out_buffer_blk_fifo.sv
// Synchronous FIFO of AES blocks with flush.
// Flush wins over pop; a same-cycle push lands in slot 0.
module blk_fifo
  import xex_buf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  aes_blk_t         din,
  output aes_blk_t         dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] waddr;
  logic [LVL_W-1:0] level_q, level_d;
  logic             wr_en, rd_en;
  aes_blk_t         mem_q [DEPTH];

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign dout  = mem_q[rptr_q];
  assign level = level_q;

  always_comb begin
    rd_en   = pop & ~empty & ~flush;
    wr_en   = push & (flush | ~full | rd_en);
    waddr   = flush ? '0 : wptr_q;
    wptr_d  = wptr_q + PTR_W'(wr_en);
    rptr_d  = rptr_q + PTR_W'(rd_en);
    level_d = level_q + LVL_W'(wr_en)
            - LVL_W'(rd_en);
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = PTR_W'(wr_en);
      level_d = LVL_W'(wr_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr] <= din;
  end

endmodule

// File: rtl/xex_out_buffer.sv
// Output buffer: queues AES blocks, serialises
// them MSB-first to 32-bit words, frames sectors.
module xex_out_buffer
  import xex_buf_pkg::*;
#(
  parameter  int DEPTH             = 4,
  parameter  int BLOCKS_PER_SECTOR = 256,
  localparam int LVL_W             = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 out_rdy,
  input  logic [AES_BLK_W-1:0] data_out,
  input  logic                 sector_start,
  output logic                 m_valid,
  output logic [WORD_W-1:0]    m_data,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 sector_done,
  output logic                 n_busy,
  output logic                 overflow,
  output logic [LVL_W-1:0]     level
);

  localparam int CNT_W =
    (BLOCKS_PER_SECTOR > 1) ? $clog2(BLOCKS_PER_SECTOR) : 1;

  word_idx_e        word_idx_q, word_idx_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             overflow_q, overflow_d;
  logic             sector_done_q, sector_done_d;

  aes_blk_t         head;
  logic             fifo_full, fifo_empty;
  logic             xfer, pop, last_blk;

  blk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_rdy),
    .pop   (pop),
    .flush (sector_start),
    .din   (data_out),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign last_blk =
    (blk_cnt_q == CNT_W'(BLOCKS_PER_SECTOR - 1));

  always_comb begin
    m_valid       = ~fifo_empty;
    m_data        = fifo_empty ? '0
                  : blk_word(head, word_idx_q);
    xfer          = m_valid & m_ready;
    m_last        = m_valid & (word_idx_q == W3) & last_blk;
    pop           = xfer & (word_idx_q == W3) & ~sector_start;
    word_idx_d    = word_idx_q;
    blk_cnt_d     = blk_cnt_q;
    overflow_d    = overflow_q;
    sector_done_d = xfer & m_last & ~sector_start;
    if (sector_start) begin
      word_idx_d = W0;
      blk_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (xfer) begin
        unique case (word_idx_q)
          W0: word_idx_d = W1;
          W1: word_idx_d = W2;
          W2: word_idx_d = W3;
          W3: word_idx_d = W0;
        endcase
      end
      if (pop) begin
        blk_cnt_d = last_blk ? '0 : blk_cnt_q + CNT_W'(1);
      end
      // Dropped block: full, and no pop frees a slot this cycle.
      if (out_rdy & fifo_full & ~pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_idx_q    <= W0;
      blk_cnt_q     <= '0;
      overflow_q    <= 1'b0;
      sector_done_q <= 1'b0;
    end else begin
      word_idx_q    <= word_idx_d;
      blk_cnt_q     <= blk_cnt_d;
      overflow_q    <= overflow_d;
      sector_done_q <= sector_done_d;
    end
  end

  assign overflow    = overflow_q;
  assign sector_done = sector_done_q;
  assign n_busy      = (level >= LVL_W'(DEPTH - 1));

endmodule

// File: tb/tb_xex_out_buffer.sv
// Self-checking bench for xex_out_buffer against
// a queue-based reference model.
module tb_xex_out_buffer;
  import xex_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int BPS   = 256;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          out_rdy = 1'b0;
  logic [127:0]  data_out = '0;
  logic          sector_start = 1'b0;
  logic          m_ready = 1'b0;
  logic          m_valid;
  logic [31:0]   m_data;
  logic          m_last;
  logic          sector_done;
  logic          n_busy;
  logic          overflow;
  logic [LW-1:0] level;

  xex_out_buffer #(
    .DEPTH             (DEPTH),
    .BLOCKS_PER_SECTOR (BPS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .out_rdy      (out_rdy),
    .data_out     (data_out),
    .sector_start (sector_start),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .sector_done  (sector_done),
    .n_busy       (n_busy),
    .overflow     (overflow),
    .level        (level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [127:0] mq[$];
  int mw = 0;
  int mb = 0;
  bit movf = 0;
  bit mdone = 0;

  int xfer_cnt, last_cnt, last_at, done_cnt;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [127:0] h;
    logic [31:0]  wd;
    wd = '0;
    if (mq.size() != 0) begin
      h  = mq[0];
      wd = h[127-32*mw -: 32];
    end
    chk({tag, ".m_valid"}, 128'(m_valid),
        128'(mq.size() != 0));
    chk({tag, ".m_data"}, 128'(m_data), 128'(wd));
    chk({tag, ".m_last"}, 128'(m_last),
        128'(mq.size() != 0 && mw == 3 && mb == BPS-1));
    chk({tag, ".n_busy"}, 128'(n_busy),
        128'(mq.size() >= DEPTH-1));
    chk({tag, ".overflow"}, 128'(overflow), 128'(movf));
    chk({tag, ".level"}, 128'(level), 128'(mq.size()));
    chk({tag, ".sector_done"}, 128'(sector_done),
        128'(mdone));
  endtask

  task automatic cycle(input string tag);
    bit xfer, pop, full;
    xfer  = (mq.size() != 0) && m_ready;
    mdone = xfer && mw == 3 && mb == BPS-1
            && !sector_start;
    if (xfer) begin
      xfer_cnt++;
      if (m_last) begin
        last_cnt++;
        last_at = xfer_cnt - 1;
      end
    end
    if (sector_start) begin
      mq.delete();
      mw = 0;
      mb = 0;
      movf = 0;
      if (out_rdy) mq.push_back(data_out);
    end else begin
      pop  = xfer && mw == 3;
      full = (mq.size() == DEPTH);
      if (out_rdy && full && !pop) movf = 1;
      if (pop) begin
        void'(mq.pop_front());
        mb = (mb + 1) % BPS;
      end
      if (xfer) mw = (mw + 1) % 4;
      if (out_rdy && !(full && !pop))
        mq.push_back(data_out);
    end
    @(posedge clk);
    #1;
    if (sector_done) done_cnt++;
    check_all(tag);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    mq.delete();
    mw = 0;
    mb = 0;
    movf = 0;
    mdone = 0;
  endtask

  logic [31:0] t1w[4];
  int pushed;

  initial begin
    t1w[0] = 32'h00112233;
    t1w[1] = 32'h44556677;
    t1w[2] = 32'h8899AABB;
    t1w[3] = 32'hCCDDEEFF;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    rst = 1'b0;

    // Single block, host always ready
    m_ready  = 1'b1;
    out_rdy  = 1'b1;
    data_out = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    cycle("t1_push");
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_word", 128'(m_data), 128'(t1w[i]));
      cycle("t1_drain");
    end
    chk("t1_empty", 128'(m_valid), 128'(0));

    // Fill with host stalled, then overflow
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_rdy  = 1'b1;
      data_out = rnd128();
      cycle("t2_fill");
      if (i == 2) chk("t2_busy3", 128'(n_busy), 128'(1));
    end
    chk("t2_level4", 128'(level), 128'(4));
    data_out = rnd128();
    cycle("t2_ovf");
    out_rdy = 1'b0;
    chk("t2_overflow", 128'(overflow), 128'(1));
    chk("t2_level_kept", 128'(level), 128'(4));
    cycle("t2_stall");
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) cycle("t2_drain");
    chk("t2_drained", 128'(level), 128'(0));

    // Push while full, coinciding with a word-3 pop
    sector_start = 1'b1;
    m_ready = 1'b0;
    cycle("t3_sector");
    sector_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_rdy  = 1'b1;
      data_out = rnd128();
      cycle("t3_fill");
    end
    out_rdy = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("t3_words");
    out_rdy  = 1'b1;
    data_out = rnd128();
    cycle("t3_pushpop");
    out_rdy = 1'b0;
    chk("t3_level", 128'(level), 128'(4));
    chk("t3_no_ovf", 128'(overflow), 128'(0));
    for (int i = 0; i < 16; i++) cycle("t3_drain");

    // Full sector with random backpressure
    sector_start = 1'b1;
    m_ready = 1'b0;
    cycle("t4_sector");
    sector_start = 1'b0;
    xfer_cnt = 0;
    last_cnt = 0;
    last_at  = -1;
    done_cnt = 0;
    pushed   = 0;
    for (int c = 0; c < 20000; c++) begin
      if (pushed == BPS && mq.size() == 0) break;
      out_rdy  = (pushed < BPS) && !n_busy
                 && ($urandom_range(0, 3) != 0);
      data_out = rnd128();
      if (out_rdy) pushed++;
      m_ready = 1'($urandom_range(0, 1));
      cycle("t4_stream");
    end
    out_rdy = 1'b0;
    chk("t4_complete", 128'(pushed == BPS && mq.size() == 0),
        128'(1));
    chk("t4_last_cnt", 128'(last_cnt), 128'(1));
    chk("t4_last_at", 128'(last_at), 128'(1023));
    chk("t4_done_cnt", 128'(done_cnt), 128'(1));
    m_ready = 1'b1;
    cycle("t4_after");
    // Next sector block counts from zero again
    out_rdy  = 1'b1;
    data_out = rnd128();
    cycle("t4_next");
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) cycle("t4_next_drain");

    // Reset mid-block
    sector_start = 1'b1;
    m_ready = 1'b0;
    cycle("t5_sector");
    sector_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      out_rdy  = 1'b1;
      data_out = rnd128();
      cycle("t5_fill");
    end
    out_rdy = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 2; i++) cycle("t5_words");
    m_ready = 1'b0;
    chk("t5_pre_level", 128'(level), 128'(3));
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t5_rst_async");
    @(posedge clk);
    #1;
    check_all("t5_rst_held");
    rst = 1'b0;

    // Overflow then sector_start with same-cycle push
    for (int i = 0; i < 5; i++) begin
      out_rdy  = 1'b1;
      data_out = rnd128();
      cycle("t5_ovf_fill");
    end
    chk("t5_ovf_set", 128'(overflow), 128'(1));
    sector_start = 1'b1;
    out_rdy  = 1'b1;
    data_out = rnd128();
    cycle("t5_ss_push");
    sector_start = 1'b0;
    out_rdy = 1'b0;
    chk("t5_ss_level", 128'(level), 128'(1));
    chk("t5_ss_ovf", 128'(overflow), 128'(0));
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle("t5_final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
